// File: rtl/dds_pkg.sv
// Shared definitions for the DDS 3-wire serial engine: FSM state encoding,
// frame geometry, default timing, and the frame-word builder.
package dds_pkg;

  localparam int unsigned INSTR_BITS        = 8;
  localparam int unsigned DATA_BITS         = 24;
  localparam int unsigned WORD_BITS         = INSTR_BITS + DATA_BITS;
  localparam int unsigned DEF_CLK_DIV       = 4;
  localparam int unsigned DEF_IOUPD_CYCLES  = 4;

  // Half-period indices within SHIFT (two half-periods per bit).
  localparam logic [5:0] INSTR_LAST_HALF = 6'(2 * INSTR_BITS - 1);
  localparam logic [5:0] DATA_FIRST_HALF = 6'(2 * INSTR_BITS);
  localparam logic [5:0] SHIFT_LAST_HALF = 6'(2 * WORD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    UPDATE
  } dds_state_e;

  // MSB of the instruction byte is the R/W flag (1 = read on the wire).
  function automatic logic [WORD_BITS-1:0] frame_word(input logic wr,
                                                      input logic [WORD_BITS-2:0] d);
    return {~wr, d};
  endfunction

endpackage

// File: rtl/dds_sclk_gen.sv
// Half-period tick generator and serial clock toggle for the DDS engine.
// tick marks the last system clock of each CLK_DIV-long half-period;
// sclk flips on a tick only while toggle is high. clr returns both to idle.
module dds_sclk_gen
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic APB_0_axiclk,
  input  logic APB_0_aresetn,
  input  logic en,
  input  logic clr,
  input  logic toggle,
  output logic tick,
  output logic sclk
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;

  // Next-state for the half-period counter and sclk level.
  always_comb begin
    tick   = en && !clr && (cnt_q == LAST);
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 8'd1;
      if (tick && toggle) sclk_d = ~sclk_q;
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge APB_0_axiclk or negedge APB_0_aresetn) begin
    if (!APB_0_aresetn) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/dds_serial_engine.sv
// DDS 3-wire serial engine: shifts a 32-bit instruction+data frame MSB first,
// turns the sdio pad around for reads, captures 24 read bits, and optionally
// pulses io_update after a write.
// Build option: define DDS_IO_UPDATE_EN to enable the UPDATE state / io_update.
module dds_serial_engine
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned IOUPD_CYCLES = DEF_IOUPD_CYCLES
) (
  input  logic        APB_0_axiclk,
  input  logic        APB_0_aresetn,
  input  logic        Start,
  input  logic [31:0] DataOut,
  input  logic        WR,
  input  logic        Send,
  output logic        Busy,
  output logic [31:0] DataIn,
  output logic        sclk,
  output logic        csn,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i,
  output logic        io_update
);

  dds_state_e state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 csn_q, csn_d;
  logic                 oe_q, oe_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [WORD_BITS-1:0] datain_q, datain_d;
  logic                 wr_q, wr_d;
  logic [5:0]           half_q, half_d;

  logic gen_en, gen_clr, gen_toggle, tick;

`ifdef DDS_IO_UPDATE_EN
  logic       send_q, send_d;
  logic [7:0] upd_cnt_q, upd_cnt_d;
  logic       io_upd_q, io_upd_d;
  logic       unused_bits;
  assign unused_bits = DataOut[31];
`else
  logic unused_bits;
  assign unused_bits = ^{DataOut[31], Send, 8'(IOUPD_CYCLES)};
`endif

  assign gen_en     = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign gen_clr    = !gen_en;
  assign gen_toggle = (state_q == SHIFT);

  dds_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .APB_0_axiclk (APB_0_axiclk),
    .APB_0_aresetn(APB_0_aresetn),
    .en           (gen_en),
    .clr          (gen_clr),
    .toggle       (gen_toggle),
    .tick         (tick),
    .sclk         (sclk)
  );

  // Transaction sequencing: latch request, shift frame, hold, optional update.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    csn_d    = csn_q;
    oe_d     = oe_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    datain_d = datain_q;
    wr_d     = wr_q;
    half_d   = half_q;
`ifdef DDS_IO_UPDATE_EN
    send_d    = send_q;
    upd_cnt_d = upd_cnt_q;
    io_upd_d  = io_upd_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          csn_d   = 1'b0;
          oe_d    = 1'b1;
          tx_d    = frame_word(WR, DataOut[30:0]);
          wr_d    = WR;
          half_d  = '0;
`ifdef DDS_IO_UPDATE_EN
          send_d  = Send;
`endif
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          half_d = half_q + 6'd1;
          if (!half_q[0]) begin
            // sclk rising: capture read data bits only
            if (!wr_q && (half_q >= DATA_FIRST_HALF)) rx_d = {rx_q[DATA_BITS-2:0], sdio_i};
          end else if (half_q == SHIFT_LAST_HALF) begin
            state_d = HOLD;
          end else begin
            // sclk falling: present next bit; release pad after instruction on reads
            tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
            if (!wr_q && (half_q == INSTR_LAST_HALF)) oe_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          csn_d = 1'b1;
          oe_d  = 1'b0;
          tx_d  = '0;
          if (!wr_q) datain_d = {{INSTR_BITS{1'b0}}, rx_q};
`ifdef DDS_IO_UPDATE_EN
          if (wr_q && send_q) begin
            state_d   = UPDATE;
            upd_cnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
`ifdef DDS_IO_UPDATE_EN
      // Count 0 is a one-clock gap after csn rises, then IOUPD_CYCLES high clocks.
      UPDATE: begin
        if (upd_cnt_q == 8'(IOUPD_CYCLES)) begin
          io_upd_d = 1'b0;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          io_upd_d  = 1'b1;
          upd_cnt_d = upd_cnt_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        csn_d   = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge APB_0_axiclk or negedge APB_0_aresetn) begin
    if (!APB_0_aresetn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      csn_q     <= 1'b1;
      oe_q      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      datain_q  <= '0;
      wr_q      <= 1'b0;
      half_q    <= '0;
`ifdef DDS_IO_UPDATE_EN
      send_q    <= 1'b0;
      upd_cnt_q <= '0;
      io_upd_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      csn_q     <= csn_d;
      oe_q      <= oe_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      datain_q  <= datain_d;
      wr_q      <= wr_d;
      half_q    <= half_d;
`ifdef DDS_IO_UPDATE_EN
      send_q    <= send_d;
      upd_cnt_q <= upd_cnt_d;
      io_upd_q  <= io_upd_d;
`endif
    end
  end

  assign Busy    = busy_q;
  assign csn     = csn_q;
  assign sdio_o  = tx_q[WORD_BITS-1];
  assign sdio_oe = oe_q;
  assign DataIn  = datain_q;
`ifdef DDS_IO_UPDATE_EN
  assign io_update = io_upd_q;
`else
  assign io_update = 1'b0;
`endif

endmodule
